triangle_assembler: RTL and testbench
=====================================

TRIANGLE_ASSEMBLER -- requirements
Module: triangle_assembler

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4, meaning triangle buffer entries (power of two, 2..16).
REQ-002 SHALL have port clk, input, 1, meaning the single clock; all logic is on its rising edge.
REQ-003 SHALL have port rst_n, input, 1, meaning reset, asynchronous and active-low.
REQ-004 SHALL have port in_valid, input, 1, meaning vertex/color/new_triangle are valid this cycle.
REQ-005 SHALL have port vertex, input, 48, meaning {x,y,z}, each 16-bit signed, x in [47:32].
REQ-006 SHALL have port color, input, 16, meaning triangle color, sampled with the first vertex only.
REQ-007 SHALL have port new_triangle, input, 1, meaning this vertex is vertex 0 of a triangle.
REQ-008 SHALL have port tri_v0/tri_v1/tri_v2, output, 48 each, meaning buffered triangle vertices in arrival order.
REQ-009 SHALL have port tri_color, output, 16, meaning color of the head triangle.
REQ-010 SHALL have port tri_valid, output, 1, meaning a head triangle is present.
REQ-011 SHALL have port tri_ready, input, 1, meaning the consumer accepts the head triangle when tri_valid && tri_ready.
REQ-012 SHALL have port proto_err, output, 1, meaning sticky framing error.
REQ-013 SHALL have port drop_count, output, 8, meaning triangles dropped (overflow/cull), saturating at 255.

Function
REQ-014 Assembly FSM SHALL have states WAIT0, HAVE1, HAVE2 and SHALL ignore inputs when in_valid=0.
REQ-015 WAIT0 with in_valid && new_triangle SHALL latch vertex to slot0 and color, then go to HAVE1.
REQ-016 WAIT0 with in_valid && !new_triangle SHALL discard the vertex, set proto_err, and stay in WAIT0.
REQ-017 HAVE1 with in_valid && !new_triangle SHALL latch slot1 and go to HAVE2.
REQ-018 HAVE2 with in_valid && !new_triangle SHALL form {slot0,slot1,vertex,color}, push it to the buffer, and go to WAIT0.
REQ-019 HAVE1/HAVE2 with in_valid && new_triangle SHALL discard the partial triangle, set proto_err, and restart as in REQ-015 (go to HAVE1).
REQ-020 A completed triangle SHALL appear with tri_valid=1 on the cycle after the third vertex edge when the buffer was empty.
REQ-021 Buffer full on completion SHALL drop the new triangle and increment drop_count, with no input backpressure.
REQ-022 A pop and a push on the same cycle while full SHALL accept the push, leaving the occupancy unchanged.
REQ-023 Outputs SHALL be stable while tri_valid && !tri_ready.
REQ-024 Buffer pointers SHALL wrap modulo FIFO_DEPTH.
REQ-025 Occupancy SHALL be log2(FIFO_DEPTH)+1 bits wide.
REQ-026 Vertex data SHALL pass bit-exact, with no arithmetic.

Reset
REQ-027 rst_n=0 SHALL immediately force: FSM=WAIT0, buffer empty, tri_valid=0, tri_v*/tri_color=0, proto_err=0, drop_count=0.
REQ-028 Reset mid-triangle or with a full buffer SHALL discard all partial and buffered data.
REQ-029 First acceptance SHALL occur on the first rising edge after rst_n deasserts.

Configuration
REQ-030 Macro TRIANGLE_ASSEMBLER_CULL_EN SHALL control degenerate-triangle culling.
REQ-031 With TRIANGLE_ASSEMBLER_CULL_EN defined, a completed triangle with any two vertices bit-equal SHALL NOT be pushed, and drop_count SHALL increment.
REQ-032 With TRIANGLE_ASSEMBLER_CULL_EN undefined, all completed triangles SHALL be pushed, subject to REQ-021.

Structure
REQ-033 Shared package graphics_pkg SHALL hold vertex_t (packed x,y,z signed 16), triangle_t (v0,v1,v2,color), and the VERTEX_W=48 and COLOR_W=16 constants.
REQ-034 The buffer SHALL be a sub-module tri_fifo (triangle_t entries, valid/ready pop, push/full, async active-low reset).
REQ-035 The assembly FSM, culling and counters SHALL reside in triangle_assembler.

Verification
REQ-036 Reset, then send 3 vertices (10,20,30)/(40,20,30)/(10,52,30) with new_triangle on the first, color 16'h0400, tri_ready=1 -> tri_valid=1 one cycle after the 3rd vertex, fields exact, proto_err=0.
REQ-037 Send 30-vertex stream (10 triangles, new_triangle every 3rd in_valid, gaps of in_valid=0 inserted), tri_ready=0 -> 4 buffered, drop_count=6; then tri_ready=1 -> first 4 triangles emerge in order.
REQ-038 Send new_triangle, vertex, new_triangle, vertex, vertex -> exactly one triangle (the last 3 vertices), proto_err=1.
REQ-039 Send 2 vertices with new_triangle=0 after reset -> no triangle, proto_err=1, FSM in WAIT0.
REQ-040 Fill buffer to 4, then on the cycle tri_ready=1 complete a triangle -> occupancy stays 4, drop_count unchanged.
REQ-041 With TRIANGLE_ASSEMBLER_CULL_EN defined, send v1==v2 -> no tri_valid, drop_count=1; without the macro -> triangle delivered.

Source files
------------

// File: rtl/graphics_pkg.sv
// graphics_pkg: shared vertex/triangle types, widths, FSM state enum and degenerate-triangle test
package graphics_pkg;
  localparam int VERTEX_W = 48;
  localparam int COLOR_W = 16;
  typedef struct packed {
    logic signed [15:0] x;
    logic signed [15:0] y;
    logic signed [15:0] z;
  } vertex_t;
  typedef struct packed {
    vertex_t v0;
    vertex_t v1;
    vertex_t v2;
    logic [COLOR_W-1:0] color;
  } triangle_t;
  typedef enum logic [1:0] {WAIT0, HAVE1, HAVE2} asm_state_t;
  function automatic logic degenerate(input vertex_t a, input vertex_t b, input vertex_t c);
    return (a == b) || (a == c) || (b == c);
  endfunction
endpackage

// File: rtl/tri_fifo.sv
// tri_fifo: triangle buffer; push/full in, pop_valid/pop_ready/pop_data out (zero when empty), accepts push when full if popping, async active-low rst_n
module tri_fifo
  import graphics_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic      clk,
  input  logic      rst_n,
  input  logic      push,
  input  triangle_t push_data,
  output logic      full,
  output triangle_t pop_data,
  output logic      pop_valid,
  input  logic      pop_ready
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  triangle_t mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0] count;
  logic pop, wr;
  assign pop_valid = count != '0;
  assign full = count == (AW+1)'(DEPTH);
  assign pop = pop_valid && pop_ready;
  assign wr = push && (!full || pop);
  assign pop_data = pop_valid ? mem[rd_ptr] : '0;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else begin
      wr_ptr <= wr ? wr_ptr + 1'b1 : wr_ptr;
      rd_ptr <= pop ? rd_ptr + 1'b1 : rd_ptr;
      count <= count + (AW+1)'(wr) - (AW+1)'(pop);
    end
  end
  always_ff @(posedge clk) begin
    if (wr) mem[wr_ptr] <= push_data;
  end
endmodule

// File: rtl/triangle_assembler.sv
// triangle_assembler: groups vertex stream into buffered triangles (in_valid/vertex/color/new_triangle in, tri_v0..2/tri_color/tri_valid/tri_ready out, proto_err, drop_count); TRIANGLE_ASSEMBLER_CULL_EN drops degenerate triangles
module triangle_assembler
  import graphics_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  input  logic [47:0] vertex,
  input  logic [15:0] color,
  input  logic        new_triangle,
  output logic [47:0] tri_v0,
  output logic [47:0] tri_v1,
  output logic [47:0] tri_v2,
  output logic [15:0] tri_color,
  output logic        tri_valid,
  input  logic        tri_ready,
  output logic        proto_err,
  output logic [7:0]  drop_count
);
  asm_state_t state;
  vertex_t slot0, slot1, v_in;
  logic [COLOR_W-1:0] col;
  triangle_t tri_new, head;
  logic complete, cull, push, drop, full, pop;
  assign v_in = vertex;
  assign tri_new = {slot0, slot1, v_in, col};
  assign complete = in_valid && !new_triangle && state == HAVE2;
  assign pop = tri_valid && tri_ready;
`ifdef TRIANGLE_ASSEMBLER_CULL_EN
  assign cull = degenerate(slot0, slot1, v_in);
`else
  assign cull = 1'b0;
`endif
  assign push = complete && !cull;
  assign drop = complete && (cull || (full && !pop));
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= WAIT0;
      slot0 <= '0;
      slot1 <= '0;
      col <= '0;
      proto_err <= 1'b0;
      drop_count <= '0;
    end else begin
      if (in_valid) begin
        if (new_triangle) begin
          slot0 <= v_in;
          col <= color;
          state <= HAVE1;
          if (state != WAIT0) proto_err <= 1'b1;
        end else if (state == WAIT0) begin
          proto_err <= 1'b1;
        end else if (state == HAVE1) begin
          slot1 <= v_in;
          state <= HAVE2;
        end else begin
          state <= WAIT0;
        end
      end
      if (drop && drop_count != 8'hff) drop_count <= drop_count + 8'd1;
    end
  end
  tri_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_data (tri_new),
    .full      (full),
    .pop_data  (head),
    .pop_valid (tri_valid),
    .pop_ready (tri_ready)
  );
  assign tri_v0 = head.v0;
  assign tri_v1 = head.v1;
  assign tri_v2 = head.v2;
  assign tri_color = head.color;
endmodule

// File: tb/tb_triangle_assembler.sv
// tb_triangle_assembler: table-driven and randomized checks against a queue-based reference model
module tb_triangle_assembler;
  localparam int DEPTH = 4;
`ifdef TRIANGLE_ASSEMBLER_CULL_EN
  localparam bit CULL = 1'b1;
`else
  localparam bit CULL = 1'b0;
`endif
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic in_valid = 1'b0, new_triangle = 1'b0, tri_ready = 1'b0;
  logic [47:0] vertex = '0;
  logic [15:0] color = '0;
  logic [47:0] tri_v0, tri_v1, tri_v2;
  logic [15:0] tri_color;
  logic tri_valid, proto_err;
  logic [7:0] drop_count;
  int total = 0, bad = 0;
  always #5 clk = ~clk;
  triangle_assembler #(.FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .vertex(vertex), .color(color),
    .new_triangle(new_triangle), .tri_v0(tri_v0), .tri_v1(tri_v1), .tri_v2(tri_v2),
    .tri_color(tri_color), .tri_valid(tri_valid), .tri_ready(tri_ready),
    .proto_err(proto_err), .drop_count(drop_count)
  );
  // reference model: count of vertices collected, partial vertices, queue of finished triangles
  logic [159:0] mq[$];
  logic [47:0] pv0, pv1;
  logic [15:0] mcol;
  int mn = 0;
  logic mperr = 1'b0;
  int mdrop = 0;
  function automatic logic [47:0] mkv(input int x, input int y, input int z);
    return {16'(x), 16'(y), 16'(z)};
  endfunction
  task automatic check(input string name, input logic [159:0] act, input logic [159:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h expected=%h", name, act, exp);
    end
  endtask
  task automatic model_reset();
    mq.delete();
    mn = 0;
    mperr = 1'b0;
    mdrop = 0;
  endtask
  task automatic model_edge(input logic iv, input logic nt, input logic [47:0] v, input logic [15:0] c, input logic rdy);
    logic [159:0] t;
    bit deg;
    if (mq.size() > 0 && rdy) void'(mq.pop_front());
    if (iv) begin
      if (nt) begin
        if (mn != 0) mperr = 1'b1;
        pv0 = v;
        mcol = c;
        mn = 1;
      end else if (mn == 0) begin
        mperr = 1'b1;
      end else if (mn == 1) begin
        pv1 = v;
        mn = 2;
      end else begin
        mn = 0;
        t = {pv0, pv1, v, mcol};
        deg = CULL && (pv0 == pv1 || pv0 == v || pv1 == v);
        if (deg || mq.size() >= DEPTH) begin
          if (mdrop < 255) mdrop++;
        end else mq.push_back(t);
      end
    end
  endtask
  task automatic model_check();
    check("valid", 160'(tri_valid), 160'(mq.size() != 0));
    if (mq.size() != 0) check("head", {tri_v0, tri_v1, tri_v2, tri_color}, mq[0]);
    check("proto_err", 160'(proto_err), 160'(mperr));
    check("drop_count", 160'(drop_count), 160'(mdrop));
  endtask
  task automatic step(input logic iv, input logic nt, input logic [47:0] v, input logic [15:0] c, input logic rdy);
    in_valid = iv;
    new_triangle = nt;
    vertex = v;
    color = c;
    tri_ready = rdy;
    @(posedge clk);
    model_edge(iv, nt, v, c, rdy);
    #1;
    model_check();
  endtask
  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    in_valid = 1'b0;
    new_triangle = 1'b0;
    tri_ready = 1'b0;
    #1;
    check("rst_valid", 160'(tri_valid), 160'(0));
    check("rst_fields", {tri_v0, tri_v1, tri_v2, tri_color}, 160'(0));
    check("rst_perr", 160'(proto_err), 160'(0));
    check("rst_drop", 160'(drop_count), 160'(0));
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask
  typedef struct packed {
    logic iv;
    logic nt;
    logic [47:0] v;
    logic [15:0] c;
    logic rdy;
    logic ev;
    logic [159:0] et;
    logic ep;
    logic [7:0] ed;
  } vec_t;
  vec_t tab[$];
  function automatic vec_t row(input logic iv, input logic nt, input logic [47:0] v, input logic [15:0] c,
                               input logic rdy, input logic ev, input logic [159:0] et, input logic ep);
    vec_t r;
    r.iv = iv; r.nt = nt; r.v = v; r.c = c; r.rdy = rdy;
    r.ev = ev; r.et = et; r.ep = ep; r.ed = 8'd0;
    return r;
  endfunction
  initial begin
    logic [47:0] a, b, cc, d, e, f, g, h;
    logic [47:0] pool [4];
    int k, got;
    a = mkv(10, 20, 30); b = mkv(40, 20, 30); cc = mkv(10, 52, 30);
    d = mkv(1, 2, 3); e = mkv(4, 5, 6); f = mkv(7, 8, 9); g = mkv(-1, -2, -3); h = mkv(100, 200, 300);
    tab.push_back(row(1, 1, a, 16'h0400, 1, 0, 0, 0));
    tab.push_back(row(1, 0, b, 16'hbeef, 1, 0, 0, 0));
    tab.push_back(row(1, 0, cc, 16'hbeef, 1, 1, {a, b, cc, 16'h0400}, 0));
    tab.push_back(row(0, 0, 48'd0, 16'h0, 1, 0, 0, 0));
    tab.push_back(row(1, 1, d, 16'h1111, 0, 0, 0, 0));
    tab.push_back(row(1, 0, e, 16'hdead, 0, 0, 0, 0));
    tab.push_back(row(1, 1, f, 16'h2222, 0, 0, 0, 1));
    tab.push_back(row(1, 0, g, 16'hdead, 0, 0, 0, 1));
    tab.push_back(row(1, 0, h, 16'hdead, 0, 1, {f, g, h, 16'h2222}, 1));
    tab.push_back(row(0, 0, 48'd0, 16'h0, 0, 1, {f, g, h, 16'h2222}, 1));
    tab.push_back(row(0, 0, 48'd0, 16'h0, 1, 0, 0, 1));
    do_reset();
    foreach (tab[i]) begin
      step(tab[i].iv, tab[i].nt, tab[i].v, tab[i].c, tab[i].rdy);
      check($sformatf("tab%0d_valid", i), 160'(tri_valid), 160'(tab[i].ev));
      if (tab[i].ev) check($sformatf("tab%0d_tri", i), {tri_v0, tri_v1, tri_v2, tri_color}, tab[i].et);
      check($sformatf("tab%0d_perr", i), 160'(proto_err), 160'(tab[i].ep));
      check($sformatf("tab%0d_drop", i), 160'(drop_count), 160'(tab[i].ed));
    end
    // two orphan vertices, then a proper triangle proves the FSM stayed in WAIT0
    do_reset();
    step(1, 0, d, 16'h1, 1);
    step(1, 0, e, 16'h2, 1);
    check("orphan_valid", 160'(tri_valid), 160'(0));
    check("orphan_perr", 160'(proto_err), 160'(1));
    step(1, 1, a, 16'h0400, 0);
    step(1, 0, b, 16'h0, 0);
    step(1, 0, cc, 16'h0, 0);
    check("after_orphan_tri", {tri_v0, tri_v1, tri_v2, tri_color}, {a, b, cc, 16'h0400});
    // 10 triangles with gaps, consumer stalled
    do_reset();
    k = 0;
    while (k < 30) begin
      if ($urandom_range(0, 2) == 0) step(0, 0, 48'(k), 16'h0, 0);
      else begin
        step(1, (k % 3) == 0, {16'(k), 16'(k + 100), 16'($urandom)}, 16'($urandom), 0);
        k++;
      end
    end
    check("burst_drop", 160'(drop_count), 160'(6));
    check("burst_first_v0", 160'(tri_v0[47:16]), 160'({16'd0, 16'd100}));
    got = 0;
    for (int i = 0; i < 8; i++) begin
      if (tri_valid) got++;
      step(0, 0, 48'd0, 16'h0, 1);
    end
    check("burst_popped", 160'(got), 160'(4));
    // full buffer: pop and push on the same edge
    do_reset();
    for (int t = 0; t < 4; t++) begin
      step(1, 1, mkv(t, 1, 1), 16'(t), 0);
      step(1, 0, mkv(t, 2, 2), 16'h0, 0);
      step(1, 0, mkv(t, 3, 3), 16'h0, 0);
    end
    step(1, 1, mkv(9, 1, 1), 16'h9, 0);
    step(1, 0, mkv(9, 2, 2), 16'h0, 0);
    step(1, 0, mkv(9, 3, 3), 16'h0, 1);
    check("full_swap_drop", 160'(drop_count), 160'(0));
    got = 0;
    for (int i = 0; i < 8; i++) begin
      if (tri_valid) got++;
      step(0, 0, 48'd0, 16'h0, 1);
    end
    check("full_swap_occupancy", 160'(got), 160'(4));
    // degenerate triangle v1 == v2
    do_reset();
    step(1, 1, a, 16'h0777, 0);
    step(1, 0, b, 16'h0, 0);
    step(1, 0, b, 16'h0, 0);
    check("degen_valid", 160'(tri_valid), 160'(!CULL));
    check("degen_drop", 160'(drop_count), 160'(CULL));
    // reset with a full buffer and a partial triangle discards everything
    do_reset();
    for (int t = 0; t < 14; t++) step(1, (t % 3) == 0, mkv(t, t, 7), 16'(t), 0);
    do_reset();
    step(1, 0, a, 16'h0, 1);
    check("post_reset_perr", 160'(proto_err), 160'(1));
    check("post_reset_empty", 160'(tri_valid), 160'(0));
    // randomized traffic against the model
    do_reset();
    pool[0] = a; pool[1] = b; pool[2] = cc; pool[3] = g;
    for (int i = 0; i < 400; i++)
      step($urandom_range(0, 3) != 0, $urandom_range(0, 3) == 0, pool[$urandom_range(0, 3)],
           16'($urandom), $urandom_range(0, 2) == 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
